// File: rtl/pool_ctrl_if.sv
// Stream, config and status bundle for pool_ctrl.
// slave = the controller, master = the feeding/draining side.
interface pool_ctrl_if #(
    parameter int W = 13
);
    logic         i_start;
    logic [8:0]   i_cfg_width;
    logic [8:0]   i_cfg_height;
    logic [W-1:0] i_data;
    logic         i_data_valid;
    logic         o_data_ready;
    logic [W-1:0] o_pool_data;
    logic         o_pool_valid;
    logic         i_pool_ready;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_start, i_cfg_width, i_cfg_height,
        output i_data, i_data_valid, i_pool_ready,
        input  o_data_ready, o_pool_data, o_pool_valid,
        input  o_busy, o_done
    );

    modport slave (
        input  i_start, i_cfg_width, i_cfg_height,
        input  i_data, i_data_valid, i_pool_ready,
        output o_data_ready, o_pool_data, o_pool_valid,
        output o_busy, o_done
    );
endinterface

// File: rtl/pool_ctrl.sv
// 2x2 stride-2 pooling sequencer over a raster pixel stream.
// Define POOL_AVG_EN for average pooling; default is signed max.
module pool_ctrl #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int MAX_WIDTH        = 512
) (
    input logic        i_clk,
    input logic        i_rst,
    pool_ctrl_if.slave bus
);
    localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [8:0]   width_q, width_d;
    logic [8:0]   height_q, height_d;
    logic [8:0]   col_q, col_d;
    logic [8:0]   row_q, row_d;
    logic [W-1:0] hold_pix_q, hold_pix_d;
    logic [W-1:0] hold_top_q, hold_top_d;
    logic [W-1:0] pool_data_q, pool_data_d;
    logic         pool_valid_q, pool_valid_d;
    logic         done_q, done_d;

    logic [W-1:0] rowbuf_q [MAX_WIDTH];
    logic [W-1:0] top_rd;

    logic in_fire, out_fire, row_end, last_row;
    logic start_ok, pool_load;
    logic [W-1:0] pool_res;

    assign bus.o_data_ready = (state_q == S_EVEN) |
                              ((state_q == S_ODD) &
                               (!pool_valid_q | bus.i_pool_ready));
    assign bus.o_pool_data  = pool_data_q;
    assign bus.o_pool_valid = pool_valid_q;
    assign bus.o_done       = done_q;
    assign bus.o_busy       = (state_q != S_IDLE) | done_q;

    assign in_fire   = bus.i_data_valid & bus.o_data_ready;
    assign out_fire  = pool_valid_q & bus.i_pool_ready;
    assign row_end   = (col_q == width_q - 9'd1);
    assign last_row  = (row_q == height_q - 9'd1);
    // done_q still counts as busy, so a start in that cycle is dropped
    assign start_ok  = bus.i_start & (state_q == S_IDLE) & !done_q;
    assign pool_load = (state_q == S_ODD) & in_fire & col_q[0];

    // Single read port: even col prefetches its top pixel into hold_top_q
    assign top_rd = rowbuf_q[col_q[AW-1:0]];

`ifdef POOL_AVG_EN
    logic signed [W+1:0] sum;
    assign sum = $signed({{2{hold_pix_q[W-1]}}, hold_pix_q}) +
                 $signed({{2{bus.i_data[W-1]}}, bus.i_data}) +
                 $signed({{2{hold_top_q[W-1]}}, hold_top_q}) +
                 $signed({{2{top_rd[W-1]}}, top_rd});
    assign pool_res = sum[W+1:2];
`else
    logic [W-1:0] max_bot, max_top;
    assign max_bot = ($signed(hold_pix_q) > $signed(bus.i_data)) ?
                     hold_pix_q : bus.i_data;
    assign max_top = ($signed(hold_top_q) > $signed(top_rd)) ?
                     hold_top_q : top_rd;
    assign pool_res = ($signed(max_bot) > $signed(max_top)) ?
                      max_bot : max_top;
`endif

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_pix_d   = hold_pix_q;
        hold_top_d   = hold_top_q;
        done_d       = 1'b0;
        pool_valid_d = pool_load | (pool_valid_q & !out_fire);
        pool_data_d  = pool_load ? pool_res : pool_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    width_d  = bus.i_cfg_width;
                    height_d = bus.i_cfg_height;
                    col_d    = 9'd0;
                    row_d    = 9'd0;
                    state_d  = S_EVEN;
                end
            end
            S_EVEN, S_ODD: begin
                if (in_fire) begin
                    if ((state_q == S_ODD) && !col_q[0]) begin
                        hold_pix_d = bus.i_data;
                        hold_top_d = top_rd;
                    end
                    if (row_end) begin
                        col_d = 9'd0;
                        row_d = row_q + 9'd1;
                        if (last_row)
                            state_d = S_DONE;
                        else
                            state_d = (state_q == S_EVEN) ? S_ODD : S_EVEN;
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            S_DONE: begin
                if (!pool_valid_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hold_pix_q   <= '0;
            hold_top_q   <= '0;
            pool_data_q  <= '0;
            pool_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_pix_q   <= hold_pix_d;
            hold_top_q   <= hold_top_d;
            pool_data_q  <= pool_data_d;
            pool_valid_q <= pool_valid_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if ((state_q == S_EVEN) && in_fire)
            rowbuf_q[col_q[AW-1:0]] <= bus.i_data;
    end
endmodule

// File: tb/tb_pool_ctrl.sv
// Randomized frame bench for pool_ctrl with a window-level reference model.
// Build with +define+POOL_AVG_EN to check the averaging variant.
module tb_pool_ctrl;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_ctrl_if #(.W(W)) bus ();

    pool_ctrl #(
        .INTEGER_BITS    (9),
        .FIXED_POINT_BITS(4),
        .MAX_WIDTH       (512)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] pix [0:1023];
    logic [W-1:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_exp(input int w, input int h);
        int a, b, c, d, v;
        expq.delete();
        for (int r = 0; r + 1 < h; r += 2) begin
            for (int k = 0; k + 1 < w; k += 2) begin
                a = pix[r*w + k];
                b = pix[r*w + k + 1];
                c = pix[(r+1)*w + k];
                d = pix[(r+1)*w + k + 1];
`ifdef POOL_AVG_EN
                v = (a + b + c + d) >>> 2;
`else
                v = a;
                if (b > v) v = b;
                if (c > v) v = c;
                if (d > v) v = d;
`endif
                expq.push_back(v[W-1:0]);
            end
        end
    endfunction

    // rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random; vmode: 0 valid=1, 1 random
    task automatic run_frame(input string name, input int w, input int h,
                             input int rmode, input int vmode);
        int idx = 0;
        int cyc = 0;
        int n = w * h;
        bit done_seen = 0;
        logic dr, pv, pr, dv, exp_dr;
        logic [W-1:0] e;
        build_exp(w, h);
        @(posedge clk); #1;
        bus.i_start      = 1'b1;
        bus.i_cfg_width  = 9'(w);
        bus.i_cfg_height = 9'(h);
        while (!done_seen && cyc < 4000) begin
            @(posedge clk); #1;
            bus.i_start      = ($urandom_range(0, 9) == 0);
            bus.i_cfg_width  = 9'($urandom_range(2, 511));
            bus.i_cfg_height = 9'($urandom_range(2, 511));
            bus.i_data_valid = (idx < n) &&
                               (vmode == 0 || $urandom_range(0, 3) != 0);
            bus.i_data       = (idx < n) ? pix[idx] : W'($urandom);
            case (rmode)
                0: bus.i_pool_ready = 1'b1;
                1: bus.i_pool_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.i_pool_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            dr = bus.o_data_ready;
            pv = bus.o_pool_valid;
            pr = bus.i_pool_ready;
            dv = bus.i_data_valid;
            if (idx >= n) exp_dr = 1'b0;
            else if ((idx / w) % 2 == 0) exp_dr = 1'b1;
            else exp_dr = !pv || pr;
            chk({name, " data_ready"}, dr, exp_dr);
            chk({name, " busy"}, bus.o_busy, 1'b1);
            if (pv && pr) begin
                checks++;
                assert (expq.size() > 0) else begin
                    errors++;
                    $error("FAIL %s extra_output observed %0h expected none",
                           name, bus.o_pool_data);
                end
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk({name, " pool_data"}, bus.o_pool_data, e);
                end
            end
            if (dv && dr) idx++;
            if (bus.o_done) begin
                done_seen = 1;
                chk({name, " done_pixels"}, idx, n);
                chk({name, " done_drained"}, expq.size(), 0);
                chk({name, " done_valid"}, pv, 1'b0);
            end
            cyc++;
        end
        checks++;
        assert (done_seen) else begin
            errors++;
            $error("FAIL %s timeout observed no_done expected done", name);
        end
        @(posedge clk); #1;
        bus.i_start      = 1'b0;
        bus.i_data_valid = 1'b0;
        @(negedge clk);
        chk({name, " busy_after"}, bus.o_busy, 1'b0);
        chk({name, " done_once"}, bus.o_done, 1'b0);
        chk({name, " valid_after"}, bus.o_pool_valid, 1'b0);
    endtask

    initial begin
        int k, tries, rw, rh;
        bus.i_start      = 1'b0;
        bus.i_cfg_width  = '0;
        bus.i_cfg_height = '0;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        bus.i_pool_ready = 1'b0;
        #3;
        chk("rst ready", bus.o_data_ready, 1'b0);
        chk("rst valid", bus.o_pool_valid, 1'b0);
        chk("rst data", bus.o_pool_data, '0);
        chk("rst busy", bus.o_busy, 1'b0);
        chk("rst done", bus.o_done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) pix[i] = W'((i + 1) * 16);
        run_frame("f4x2", 4, 2, 0, 0);

        pix[0] = W'(-16); pix[1] = W'(-48);
        pix[2] = W'(-32); pix[3] = W'(-64);
        run_frame("neg", 2, 2, 0, 0);

        for (int i = 0; i < 32; i++) pix[i] = W'($urandom);
        run_frame("bp8x4", 8, 4, 1, 0);

        for (int i = 0; i < 15; i++) pix[i] = W'($urandom);
        run_frame("odd5x3", 5, 3, 2, 1);

        pix[0] = W'(16); pix[1] = W'(32); pix[2] = W'(48); pix[3] = W'(80);
        run_frame("win_a", 2, 2, 0, 0);
        pix[0] = W'(-16); pix[1] = W'(-16);
        pix[2] = W'(-16); pix[3] = W'(-32);
        run_frame("win_b", 2, 2, 0, 0);
        pix[0] = W'(1); pix[1] = W'(0); pix[2] = W'(0); pix[3] = W'(0);
        run_frame("win_c", 2, 2, 0, 0);

        for (int f = 0; f < 4; f++) begin
            rw = $urandom_range(2, 9);
            rh = $urandom_range(2, 6);
            for (int i = 0; i < rw * rh; i++) pix[i] = W'($urandom);
            run_frame("rand", rw, rh, 2, 1);
        end

        // Park a result in the output register mid odd row, then reset
        for (int i = 0; i < 8; i++) pix[i] = W'($urandom);
        @(posedge clk); #1;
        bus.i_start      = 1'b1;
        bus.i_cfg_width  = 9'd4;
        bus.i_cfg_height = 9'd2;
        k = 0;
        tries = 0;
        while (k < 6 && tries < 50) begin
            @(posedge clk); #1;
            bus.i_start      = 1'b0;
            bus.i_data_valid = 1'b1;
            bus.i_data       = pix[k];
            bus.i_pool_ready = 1'b0;
            @(negedge clk);
            if (bus.o_data_ready) k++;
            tries++;
        end
        @(posedge clk); #1;
        bus.i_data_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst valid", bus.o_pool_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst ready", bus.o_data_ready, 1'b0);
        chk("mid_rst valid", bus.o_pool_valid, 1'b0);
        chk("mid_rst data", bus.o_pool_data, '0);
        chk("mid_rst busy", bus.o_busy, 1'b0);
        chk("mid_rst done", bus.o_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_pool_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst valid", bus.o_pool_valid, 1'b0);
        end

        for (int i = 0; i < 4; i++) pix[i] = W'($urandom);
        run_frame("post_rst", 2, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
- Sequencing controller for 2x2, stride-2 pooling on a streamed feature map.
- Accepts one fixed-point pixel per handshake in raster order and stores each even row in an internal row buffer.
- While the following odd row streams in, pairs that row with the stored row and emits one pooled value per 2x2 window.
- Sits between the convolution output stream and the next layer's input buffer.

Parameters:
- INTEGER_BITS, 9, integer bits of signed two's-complement pixel.
- FIXED_POINT_BITS, 4, fractional bits.
- MAX_WIDTH, 512, row buffer depth; must be at least the largest cfg_width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse; latches cfg and starts a frame. Ignored unless IDLE.
- i_cfg_width  in  9  pixels per input row; legal range 2..MAX_WIDTH.
- i_cfg_height  in  9  input rows; legal range 2..511.
- i_data  in  W  input pixel, where W = INTEGER_BITS+FIXED_POINT_BITS.
- i_data_valid  in  1  input pixel valid.
- o_data_ready  out  1  controller can accept a pixel.
- o_pool_data  out  W  pooled value.
- o_pool_valid  out  1  pooled value valid.
- i_pool_ready  in  1  downstream accepts the pooled value.
- o_busy  out  1  high from start until done.
- o_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset (async, i_rst=1):
  - State = IDLE; all counters and registers = 0.
  - o_data_ready=0, o_pool_valid=0, o_pool_data=0, o_busy=0, o_done=0.
  - Reset mid-frame abandons the frame immediately; no output is emitted afterwards.
- Transfer rules:
  - An input transfer occurs when i_data_valid & o_data_ready.
  - An output transfer occurs when o_pool_valid & i_pool_ready.
- States:
  - IDLE -> EVEN on i_start. Width and height are latched; col=0, row=0.
  - EVEN: o_data_ready=1. Each transfer writes rowbuf[col]. At col==width-1, col wraps to 0, row increments, and the state goes to ODD. If that was the last row, the state goes to DONE instead.
  - ODD: o_data_ready = !o_pool_valid | i_pool_ready (one-entry output register, no bubble under continuous ready).
    - Even col: pixel is captured into a hold register.
    - Odd col: the result of the pooling function over hold, current pixel, rowbuf[col-1] and rowbuf[col] is registered into o_pool_data. o_pool_valid asserts on the next edge (latency 1 cycle from the accepting edge).
    - At row end: col wraps, row increments. Next state is EVEN, or DONE if the last row was accepted.
  - DONE: o_data_ready=0. Waits until o_pool_valid==0 (final result drained), then pulses o_done for one cycle and returns to IDLE. o_busy is high from the cycle after i_start through the o_done cycle.
- Pooling function (default): signed maximum of the four values.
- Boundary conditions:
  - Odd width: the final column pixel is accepted and discarded. Outputs per odd row = floor(width/2).
  - Odd height: the final row is stored in EVEN and no outputs are produced for it.
  - An output transfer and a new result load in the same cycle are allowed. The register takes the new value and valid stays 1.
  - i_start while busy is ignored. Config inputs are sampled only on an accepted i_start.
  - cfg_width or cfg_height below 2 is illegal; behaviour is undefined.
  - The row buffer is written only in EVEN and is read at both odd-col addresses in the same cycle (dual-read or registered prefetch is implementation choice). Observable latency must match the above.

Optional Feature:
- Macro: POOL_AVG_EN.
- When defined, the pooling function is average instead of maximum:
  - The four values are sign-extended to W+2 bits and summed.
  - The sum is arithmetic-shifted right by 2 (rounds toward negative infinity) and truncated to W.
- When undefined, the pooling function is signed maximum.
- Latency and handshake are identical either way.

Test Plan:
- 4x2 frame, row0 = 1,2,3,4 and row1 = 5,6,7,8 (integer values, Q9.4 encoded), ready held 1 -> two outputs 6.0 then 8.0; o_done pulses once; o_busy drops the cycle after.
- Negative data max: rows -1,-3 and -2,-4, width 2, height 2 -> single output -1.0 (checks the signed compare).
- Back-pressure: 8x4 frame with i_pool_ready toggling 1,0,0,1 -> no lost or duplicated outputs, 8 outputs in raster order, and o_data_ready low whenever the output register is full and not draining.
- Odd dims: width 5, height 3 -> 2 outputs; the 5th column of each row and all of row 2 are consumed without output; o_done pulses.
- Async reset asserted mid-ODD row with o_pool_valid=1 -> all outputs 0 immediately. A new i_start then runs a clean 2x2 frame with the correct result.
- With POOL_AVG_EN: window 1,2,3,5 -> 2.75; window -1,-1,-1,-2 -> -1.25; window values 0.0625,0,0,0 -> 0.0 (floor).
